// File: rtl/vec_csr_regs.sv
// ---------------------------------------------------------------------------
// vec_csr_regs
//
// Vector configuration CSR block. It executes vsetvli / vsetivli / vsetvl
// requests from decode through a three-state sequence (IDLE -> CALC -> COMMIT).
// It holds the architectural vl, vtype and vstart registers, and it publishes
// the decoded SEW, LMUL, vill and current VLMAX.
//
// Ports
//   clk             in   sole clock, rising edge
//   reset           in   synchronous, active-high reset
//   csr_req_valid   in   vset* request from decode
//   csr_req_ready   out  high only while idle
//   scalar1         in   AVL (rs1 data or zero-extended uimm)
//   scalar2         in   requested vtype (rs2 data or zero-extended zimm)
//   avl_is_imm      in   request is vsetivli (rs1_is_x0 ignored)
//   rs1_is_x0       in   rs1 field is x0
//   rd_is_x0        in   rd field is x0
//   vstart_wr_en    in   vstart write strobe from load/store unit
//   vstart_wr_data  in   vstart write value
//   csr_done        out  one-cycle pulse after commit
//   csr_rd_data     out  committed vl while csr_done is high, else zero
//   vl/vtype/vstart out  architectural state
//   vlmax           out  VLMAX of committed vtype (zero when vill)
//   sew/lmul/vill   out  decoded fields of committed vtype
// ---------------------------------------------------------------------------
module vec_csr_regs #(
    parameter int XLEN = 32,
    parameter int VLEN = 512
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            csr_req_valid,
    output logic            csr_req_ready,
    input  logic [XLEN-1:0] scalar1,
    input  logic [XLEN-1:0] scalar2,
    input  logic            avl_is_imm,
    input  logic            rs1_is_x0,
    input  logic            rd_is_x0,
    input  logic            vstart_wr_en,
    input  logic [XLEN-1:0] vstart_wr_data,
    output logic            csr_done,
    output logic [XLEN-1:0] csr_rd_data,
    output logic [XLEN-1:0] vl,
    output logic [XLEN-1:0] vtype,
    output logic [XLEN-1:0] vstart,
    output logic [XLEN-1:0] vlmax,
    output logic [2:0]      sew,
    output logic [2:0]      lmul,
    output logic            vill
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CALC   = 2'd1,
        S_COMMIT = 2'd2
    } state_e;

    localparam logic [XLEN-1:0] ZERO_W    = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] VTYPE_ILL = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] VLEN_W    = XLEN'(VLEN);

    // VLMAX = (VLEN / SEW) * LMUL, where SEW = 8 << vsew. Shifts only.
    function automatic logic [XLEN-1:0] vlmax_of(input logic [2:0] sew_f,
                                                 input logic [2:0] lmul_f);
        logic [3:0] sh;
        sh = 4'd3 + {1'b0, sew_f};
        return (VLEN_W >> sh) << lmul_f;
    endfunction

    // Unsigned minimum over the full XLEN width.
    function automatic logic [XLEN-1:0] umin(input logic [XLEN-1:0] a,
                                             input logic [XLEN-1:0] b);
        return (a < b) ? a : b;
    endfunction

    state_e          state_q, state_d;

    // Request captured at acceptance; frozen until the next idle acceptance.
    logic [XLEN-1:0] avl_q, avl_d;
    logic [XLEN-1:0] req_vtype_q, req_vtype_d;
    logic            imm_q, imm_d;
    logic            rs1_x0_q, rs1_x0_d;
    logic            rd_x0_q, rd_x0_d;

    // Results of the CALC stage.
    logic [XLEN-1:0] new_vlmax_q, new_vlmax_d;
    logic            new_vill_q, new_vill_d;

    // Architectural state and registered handshake outputs.
    logic [XLEN-1:0] vl_q, vl_d;
    logic [XLEN-1:0] vtype_q, vtype_d;
    logic [XLEN-1:0] vstart_q, vstart_d;
    logic            done_q, done_d;
    logic [XLEN-1:0] rd_data_q, rd_data_d;

    logic [XLEN-1:0] commit_vl;
    logic            req_illegal;

    // Legality of the captured vtype: reserved high bits, SEW above 32, or
    // fractional/reserved LMUL all make the configuration illegal.
    always_comb begin
        req_illegal = (|req_vtype_q[XLEN-1:8])
                    | (req_vtype_q[5:3] > 3'b010)
                    | req_vtype_q[2];
    end

    // New vl for a legal configuration, chosen by the AVL-source encoding.
    always_comb begin
        commit_vl = ZERO_W;
        if (new_vill_q) begin
            commit_vl = ZERO_W;
        end else if (imm_q || !rs1_x0_q) begin
            commit_vl = umin(avl_q, new_vlmax_q);
        end else if (!rd_x0_q) begin
            commit_vl = new_vlmax_q;
        end else begin
            // Both x0: keep the old vl but clamp it to the new VLMAX.
            commit_vl = umin(vl_q, new_vlmax_q);
        end
    end

    // FSM next-state and datapath next-state.
    always_comb begin
        state_d     = state_q;
        avl_d       = avl_q;
        req_vtype_d = req_vtype_q;
        imm_d       = imm_q;
        rs1_x0_d    = rs1_x0_q;
        rd_x0_d     = rd_x0_q;
        new_vlmax_d = new_vlmax_q;
        new_vill_d  = new_vill_q;
        vl_d        = vl_q;
        vtype_d     = vtype_q;
        done_d      = 1'b0;
        rd_data_d   = ZERO_W;

        // vstart can be written in any state; a commit below overrides it.
        if (vstart_wr_en) begin
            vstart_d = vstart_wr_data;
        end else begin
            vstart_d = vstart_q;
        end

        case (state_q)
            S_IDLE: begin
                if (csr_req_valid) begin
                    avl_d       = scalar1;
                    req_vtype_d = scalar2;
                    imm_d       = avl_is_imm;
                    rs1_x0_d    = rs1_is_x0;
                    rd_x0_d     = rd_is_x0;
                    state_d     = S_CALC;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                new_vill_d = req_illegal;
                if (req_illegal) begin
                    new_vlmax_d = ZERO_W;
                end else begin
                    new_vlmax_d = vlmax_of(req_vtype_q[5:3], req_vtype_q[2:0]);
                end
                state_d = S_COMMIT;
            end
            S_COMMIT: begin
                vl_d      = commit_vl;
                rd_data_d = commit_vl;
                done_d    = 1'b1;
                vstart_d  = ZERO_W;
                if (new_vill_q) begin
                    vtype_d = VTYPE_ILL;
                end else begin
                    vtype_d = {1'b0, req_vtype_q[XLEN-2:0]};
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            avl_q       <= ZERO_W;
            req_vtype_q <= ZERO_W;
            imm_q       <= 1'b0;
            rs1_x0_q    <= 1'b0;
            rd_x0_q     <= 1'b0;
            new_vlmax_q <= ZERO_W;
            new_vill_q  <= 1'b1;
            vl_q        <= ZERO_W;
            vtype_q     <= VTYPE_ILL;
            vstart_q    <= ZERO_W;
            done_q      <= 1'b0;
            rd_data_q   <= ZERO_W;
        end else begin
            state_q     <= state_d;
            avl_q       <= avl_d;
            req_vtype_q <= req_vtype_d;
            imm_q       <= imm_d;
            rs1_x0_q    <= rs1_x0_d;
            rd_x0_q     <= rd_x0_d;
            new_vlmax_q <= new_vlmax_d;
            new_vill_q  <= new_vill_d;
            vl_q        <= vl_d;
            vtype_q     <= vtype_d;
            vstart_q    <= vstart_d;
            done_q      <= done_d;
            rd_data_q   <= rd_data_d;
        end
    end

    // Decode of the committed vtype; everything reads as zero when illegal.
    always_comb begin
        vill = vtype_q[XLEN-1];
        if (vtype_q[XLEN-1]) begin
            sew   = 3'd0;
            lmul  = 3'd0;
            vlmax = ZERO_W;
        end else begin
            sew   = vtype_q[5:3];
            lmul  = vtype_q[2:0];
            vlmax = vlmax_of(vtype_q[5:3], vtype_q[2:0]);
        end
    end

    assign csr_req_ready = (state_q == S_IDLE);
    assign csr_done      = done_q;
    assign csr_rd_data   = rd_data_q;
    assign vl            = vl_q;
    assign vtype         = vtype_q;
    assign vstart        = vstart_q;

endmodule

// File: doc/vec_csr_regs.md
VEC_CSR_REGS -- requirements
Module: vec_csr_regs

Interface
REQ-001 SHALL have parameter XLEN, default 32, scalar and CSR width.
REQ-002 SHALL have parameter VLEN, default 512, vector register length in bits.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port csr_req_valid  input  1  vset* request from decode stage.
REQ-006 SHALL have port csr_req_ready  output  1  block can accept a request.
REQ-007 SHALL have port scalar1  input  XLEN  AVL (rs1 data or zero-extended uimm).
REQ-008 SHALL have port scalar2  input  XLEN  requested vtype (rs2 data or zero-extended zimm).
REQ-009 SHALL have port avl_is_imm  input  1  request is vsetivli; rs1_is_x0 is ignored.
REQ-010 SHALL have port rs1_is_x0  input  1  rs1 field equals x0.
REQ-011 SHALL have port rd_is_x0  input  1  rd field equals x0.
REQ-012 SHALL have port vstart_wr_en  input  1  vstart write from load/store unit.
REQ-013 SHALL have port vstart_wr_data  input  XLEN  vstart write value.
REQ-014 SHALL have port csr_done  output  1  one-cycle pulse on commit.
REQ-015 SHALL have port csr_rd_data  output  XLEN  new vl, for scalar rd writeback; valid with csr_done.
REQ-016 SHALL have ports vl, vtype, vstart, vlmax  output  XLEN each  architectural state and current VLMAX.
REQ-017 SHALL have ports sew  output  3 (vsew), lmul  output  3 (vlmul), vill  output  1.

Function
REQ-018 FSM states SHALL be S_IDLE, S_CALC, S_COMMIT; csr_req_ready SHALL be 1 only in S_IDLE.
REQ-019 S_IDLE with csr_req_valid=1 SHALL capture scalar1, scalar2, avl_is_imm, rs1_is_x0, rd_is_x0 and go to S_CALC; otherwise remain in S_IDLE.
REQ-020 S_CALC SHALL decode captured vtype, register the new VLMAX and vill flag, go to S_COMMIT.
REQ-021 S_COMMIT SHALL update vl/vtype/vstart, pulse csr_done for exactly one cycle, return to S_IDLE.
REQ-022 Latency: request accepted at edge T -> csr_done high in cycle after edge T+2; next request acceptable in the cycle csr_done is high is NOT allowed (ready=0 until S_IDLE).
REQ-023 vill SHALL be set if vtype[XLEN-1:8] != 0, vsew > 3'b010 (SEW>32), or vlmul[2]=1 (fractional/reserved LMUL).
REQ-024 VLMAX SHALL equal (VLEN >> (3+vsew)) << vlmul, computed by shifts only (e.g. VLEN=512, SEW8, LMUL1 -> 64; SEW32, LMUL8 -> 128).
REQ-025 vl rules, legal vtype: avl_is_imm or rs1_is_x0=0 -> vl = min(AVL, VLMAX); rs1_is_x0=1, rd_is_x0=0 -> vl = VLMAX; both x0 -> vl = min(old vl, VLMAX).
REQ-026 AVL comparison SHALL be unsigned, full XLEN width.
REQ-027 On commit with vill: vtype SHALL be {1'b1, (XLEN-1)'b0}, vl SHALL be 0, sew/lmul SHALL be 0.
REQ-028 On commit with legal vtype: vtype SHALL be {1'b0, scalar2[XLEN-2:0]}, sew/lmul SHALL equal vtype[5:3]/vtype[2:0].
REQ-029 csr_rd_data SHALL equal the committed vl; it SHALL be 0 when csr_done=0.
REQ-030 Every commit SHALL clear vstart to 0.
REQ-031 vstart_wr_en SHALL load vstart_wr_data in any state; if coinciding with S_COMMIT, the commit clear SHALL win.
REQ-032 vlmax output SHALL reflect the committed vtype, combinationally decoded; it SHALL be 0 when vill=1.
REQ-033 Changes to csr_req_valid or data inputs outside S_IDLE SHALL be ignored.

Reset
REQ-034 reset=1 at a clock edge SHALL force S_IDLE, vl=0, vstart=0, vtype=0x8000_0000, vill=1, sew=0, lmul=0, csr_done=0, csr_rd_data=0.
REQ-035 Reset in S_CALC or S_COMMIT SHALL abort the request; no csr_done SHALL be produced and the state SHALL take reset values.
REQ-036 After reset release, csr_req_ready SHALL be 1 in the first cycle.

Verification
REQ-037 vsetvli AVL=100, vtype=0x000 (SEW8,LMUL1) -> csr_done at T+2, vl=64, vtype=0x0, vlmax=64, csr_rd_data=64.
REQ-038 vsetvli rs1=x0, rd!=x0, vtype=0x013 (SEW32,LMUL8) -> vl=128; then rs1=x0, rd=x0, vtype=0x010 (SEW32,LMUL1) -> vl=16.
REQ-039 vsetvl with scalar2=0x018 (SEW64) -> vill=1, vtype=0x8000_0000, vl=0, vlmax=0; likewise scalar2=0x005 (LMUL 1/8).
REQ-040 vsetivli uimm=5, rs1_is_x0=1, vtype=0x008 (SEW16) -> vl=5, not VLMAX.
REQ-041 vstart_wr_en=1 data=7 in S_IDLE -> vstart=7; vstart write coincident with S_COMMIT -> vstart=0.
REQ-042 reset asserted in S_CALC -> no csr_done, vill=1, vl=0, ready=1 the cycle after reset drops; back-to-back valid held high -> one request accepted per 3 cycles.
